// File: rtl/gsim_rot_window_if.sv
// gsim_rot_window_if: command and sweep handshake bundle for gsim_rot_window.
// master drives commands/sw_ready; slave drives cmd_ready and sweep data.
interface gsim_rot_window_if #(
  parameter int BIT_WIDTH = 32,
  parameter int SHW       = 3
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [SHW-1:0]       cmd_shift;
  logic [1:0]           cmd_load;
  logic [BIT_WIDTH-1:0] in0_data;
  logic [BIT_WIDTH-1:0] in1_data;
  logic                 sw_valid;
  logic                 sw_ready;
  logic [BIT_WIDTH-1:0] sw_data;
  logic                 sw_last;

  modport master (
    output cmd_valid, cmd_op, cmd_shift, cmd_load,
    output in0_data, in1_data, sw_ready,
    input  cmd_ready, sw_valid, sw_data, sw_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_shift, cmd_load,
    input  in0_data, in1_data, sw_ready,
    output cmd_ready, sw_valid, sw_data, sw_last
  );
endinterface

// File: rtl/gsim_rot_window.sv
// gsim_rot_window: DEPTH-entry circular operand window; ROT/SWEEP/CLEAR/NOP.
// Ports: clk, rst_n (async, active-high), bus (slave), window_o, occ_o,
// err_o only when GSIM_ROTWIN_ERR_EN is defined (sticky illegal shift).
module gsim_rot_window #(
  parameter int BIT_WIDTH = 32,
  parameter int DEPTH     = 16,
  parameter int MAX_SHIFT = 5,
  parameter int IN1_SLOT  = 1,
  parameter int SHW       = 3,
  parameter int OCW       = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  gsim_rot_window_if.slave           bus,
  output logic [DEPTH*BIT_WIDTH-1:0] window_o,
  output logic [OCW-1:0]             occ_o
`ifdef GSIM_ROTWIN_ERR_EN
  ,
  output logic                       err_o
`endif
);
  localparam int CW = $clog2(DEPTH);
  localparam logic [SHW-1:0] KMAX  = SHW'(MAX_SHIFT);
  localparam logic [OCW:0]   OMAX  = (OCW+1)'(DEPTH);
  localparam logic [CW-1:0]  CLAST = CW'(DEPTH-1);

  typedef logic [BIT_WIDTH-1:0] word_t;
  typedef enum logic {IDLE, SWEEP} state_t;

  state_t         state, state_nxt;
  word_t          win     [DEPTH];
  word_t          win_nxt [DEPTH];
  word_t          rot_k   [DEPTH];
  word_t          rot_1   [DEPTH];
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [OCW-1:0] occ, occ_nxt;
  logic [OCW:0]   occ_sum;
  logic [SHW-1:0] k;
  logic           rdy, swv, last, acc, hs;
  logic           is_rot, shift_bad, rot_ok;
  logic           do_rot, do_sweep, do_clr;

  assign rdy  = (state == IDLE);
  assign swv  = (state == SWEEP);
  assign last = swv && (cnt == CLAST);
  assign acc  = bus.cmd_valid & rdy;
  assign hs   = swv & bus.sw_ready;

  assign bus.cmd_ready = rdy;
  assign bus.sw_valid  = swv;
  assign bus.sw_last   = last;
  assign bus.sw_data   = win[0];

  assign is_rot    = acc && (bus.cmd_op == 2'b00);
  assign shift_bad = bus.cmd_shift > KMAX;

`ifdef GSIM_ROTWIN_ERR_EN
  // Illegal shift is rejected whole: no rotate, no insert.
  assign k      = bus.cmd_shift;
  assign rot_ok = ~shift_bad;
`else
  assign k      = shift_bad ? KMAX : bus.cmd_shift;
  assign rot_ok = 1'b1;
`endif

  assign do_rot   = is_rot & rot_ok;
  assign do_sweep = acc && (bus.cmd_op == 2'b01);
  assign do_clr   = acc && (bus.cmd_op == 2'b10);

  assign occ_sum = {1'b0, occ}
                 + (OCW+1)'(bus.cmd_load[0])
                 + (OCW+1)'(bus.cmd_load[1]);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rot_k[i] = win[CW'((i + int'(k)) % DEPTH)];
      rot_1[i] = win[CW'((i + 1) % DEPTH)];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign window_o[g*BIT_WIDTH +: BIT_WIDTH] = win[g];
  end
  assign occ_o = occ;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (do_sweep)   state_nxt = SWEEP;
      SWEEP: if (hs && last) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    win_nxt = win;
    occ_nxt = occ;
    cnt_nxt = cnt;
    unique case (1'b1)
      do_rot: begin
        win_nxt = rot_k;
        if (bus.cmd_load[0]) win_nxt[DEPTH-1]  = bus.in0_data;
        if (bus.cmd_load[1]) win_nxt[IN1_SLOT] = bus.in1_data;
        occ_nxt = (occ_sum > OMAX) ? OCW'(DEPTH) : occ_sum[OCW-1:0];
      end
      do_clr: begin
        for (int i = 0; i < DEPTH; i++) win_nxt[i] = '0;
        occ_nxt = '0;
      end
      do_sweep: cnt_nxt = '0;
      // DEPTH single-step rotates bring the window back home.
      hs: begin
        win_nxt = rot_1;
        cnt_nxt = cnt + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      cnt <= '0;
      occ <= '0;
    end else begin
      win <= win_nxt;
      cnt <= cnt_nxt;
      occ <= occ_nxt;
    end
  end

`ifdef GSIM_ROTWIN_ERR_EN
  logic err;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                   err <= 1'b0;
    else if (is_rot & shift_bad) err <= 1'b1;
  end
  assign err_o = err;
`endif
endmodule

// File: tb/tb_gsim_rot_window.sv
// tb_gsim_rot_window: directed + random checks against a queue-based model.
// Default parameters (DEPTH 16, MAX_SHIFT 5, IN1_SLOT 1).
module tb_gsim_rot_window;
  typedef logic [511:0] v_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] window_o;
  logic [4:0]   occ_o;
`ifdef GSIM_ROTWIN_ERR_EN
  logic         err_o;
`endif

  gsim_rot_window_if #(.BIT_WIDTH(32), .SHW(3)) bus ();

  gsim_rot_window dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .window_o (window_o),
    .occ_o    (occ_o)
`ifdef GSIM_ROTWIN_ERR_EN
    ,
    .err_o    (err_o)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m [16];
  int          mocc;
  bit          merr;

  task automatic chk(input string tag, input v_t got, input v_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int i);
    return window_o[i*32 +: 32];
  endfunction

  function automatic v_t pack_m();
    v_t r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = m[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = '0;
    mocc = 0;
    merr = 0;
  endtask

  // Rotation as a queue: k times move the head word to the tail.
  task automatic model_cmd(input logic [1:0] op, input int k,
                           input logic [1:0] ld,
                           input logic [31:0] d0, input logic [31:0] d1);
    logic [31:0] q [$];
    bit          skip;
    skip = 0;
    if (op == 2'b00) begin
      if (k > 5) begin
`ifdef GSIM_ROTWIN_ERR_EN
        merr = 1;
        skip = 1;
`else
        k = 5;
`endif
      end
      if (!skip) begin
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(m[i]);
        repeat (k) q.push_back(q.pop_front());
        for (int i = 0; i < 16; i++) m[i] = q[i];
        if (ld[0]) m[15] = d0;
        if (ld[1]) m[1]  = d1;
        mocc = mocc + int'(ld[0]) + int'(ld[1]);
        if (mocc > 16) mocc = 16;
      end
    end else if (op == 2'b10) begin
      for (int i = 0; i < 16; i++) m[i] = '0;
      mocc = 0;
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input int k,
                        input logic [1:0] ld,
                        input logic [31:0] d0, input logic [31:0] d1);
    int w;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_shift = 3'(k);
    bus.cmd_load  = ld;
    bus.in0_data  = d0;
    bus.in1_data  = d1;
    w = 0;
    while (!bus.cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_ready) begin
      chk("cmd_ready_timeout", v_t'(bus.cmd_ready), v_t'(1));
      bus.cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      model_cmd(op, k, ld, d0, d1);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_win"}, window_o, pack_m());
    chk({tag, "_occ"}, v_t'(occ_o), v_t'(mocc));
`ifdef GSIM_ROTWIN_ERR_EN
    chk({tag, "_err"}, v_t'(err_o), v_t'(merr));
`endif
  endtask

  // Entries become i=i (entry0 holds a rotated-in zero), occ 15.
  task automatic preload();
    do_cmd(2'b10, 0, 2'b00, 0, 0);
    for (int v = 1; v < 16; v++) do_cmd(2'b00, 1, 2'b01, 32'(v), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int hs, cyc, r;
    bit done;
    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b11;
    bus.cmd_shift = '0;
    bus.cmd_load  = '0;
    bus.in0_data  = '0;
    bus.in1_data  = '0;
    bus.sw_ready  = 1'b0;
    model_reset();

    #12;
    chk("rst_win", window_o, v_t'(0));
    chk("rst_occ", v_t'(occ_o), v_t'(0));
    chk("rst_swv", v_t'(bus.sw_valid), v_t'(0));
    chk("rst_swl", v_t'(bus.sw_last), v_t'(0));
`ifdef GSIM_ROTWIN_ERR_EN
    chk("rst_err", v_t'(err_o), v_t'(0));
`endif
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_rdy", v_t'(bus.cmd_ready), v_t'(1));

    preload();
    check_state("preload");
    do_cmd(2'b00, 5, 2'b00, 0, 0);
    chk("rot_e0",  v_t'(ent(0)),  v_t'(5));
    chk("rot_e10", v_t'(ent(10)), v_t'(15));
    chk("rot_e11", v_t'(ent(11)), v_t'(0));
    chk("rot_e15", v_t'(ent(15)), v_t'(4));
    check_state("rot");

    preload();
    do_cmd(2'b00, 4, 2'b11, 32'hAA, 32'hBB);
    chk("dual_e15", v_t'(ent(15)), v_t'(32'hAA));
    chk("dual_e1",  v_t'(ent(1)),  v_t'(32'hBB));
    chk("dual_e0",  v_t'(ent(0)),  v_t'(4));
    chk("dual_e12", v_t'(ent(12)), v_t'(0));
    chk("dual_occ", v_t'(occ_o),   v_t'(16));

    do_cmd(2'b10, 0, 2'b00, 0, 0);
    do_cmd(2'b00, 0, 2'b11, 32'h11, 32'h22);
    chk("inc_occ", v_t'(occ_o), v_t'(2));
    check_state("inc");

    preload();
    do_cmd(2'b11, 3, 2'b11, 32'h77, 32'h88);
    check_state("nop");

    // Sweep with 1,0,1 backpressure; a CLEAR is held on cmd during it.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    @(posedge clk);
    #1;
    bus.cmd_op = 2'b10;
    hs   = 0;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.sw_ready = (cyc % 3) != 2;
      if (cyc == 2) chk("sw_cmd_rdy", v_t'(bus.cmd_ready), v_t'(0));
      if (bus.sw_valid && bus.sw_ready) begin
        chk("sw_data", v_t'(bus.sw_data), v_t'(hs));
        chk("sw_last", v_t'(bus.sw_last), v_t'(hs == 15));
        hs++;
        if (bus.sw_last || hs >= 16) begin
          done = 1;
          bus.cmd_valid = 1'b0;
        end
      end
    end
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.sw_ready = 1'b0;
    chk("sw_hs_cnt", v_t'(hs), v_t'(16));
    chk("sw_done_rdy", v_t'(bus.cmd_ready), v_t'(1));
    chk("sw_done_swv", v_t'(bus.sw_valid), v_t'(0));
    check_state("sw_restore");

    do_cmd(2'b10, 0, 2'b00, 0, 0);
    for (int i = 0; i < 20; i++)
      do_cmd(2'b00, int'($urandom_range(0, 5)), 2'b01, $urandom, 0);
    chk("sat_occ", v_t'(occ_o), v_t'(16));
    check_state("sat");
    do_cmd(2'b10, 0, 2'b00, 0, 0);
    chk("clr_win", window_o, v_t'(0));
    chk("clr_occ", v_t'(occ_o), v_t'(0));

    preload();
    do_cmd(2'b00, 7, 2'b00, 0, 0);
`ifdef GSIM_ROTWIN_ERR_EN
    chk("ill_e0",  v_t'(ent(0)), v_t'(0));
    chk("ill_err", v_t'(err_o),  v_t'(1));
    do_cmd(2'b00, 1, 2'b00, 0, 0);
    chk("ill_sticky", v_t'(err_o), v_t'(1));
`else
    chk("ill_e0", v_t'(ent(0)), v_t'(5));
`endif
    check_state("ill");

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)
        do_cmd(2'b00, int'($urandom_range(0, 7)), 2'($urandom),
               $urandom, $urandom);
      else if (r < 9)
        do_cmd(2'b11, int'($urandom_range(0, 7)), 2'($urandom),
               $urandom, $urandom);
      else
        do_cmd(2'b10, 0, 2'b00, 0, 0);
      check_state("rand");
    end

    preload();
    do_cmd(2'b01, 0, 2'b00, 0, 0);
    bus.sw_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_reset();
    chk("rmid_win", window_o, v_t'(0));
    chk("rmid_occ", v_t'(occ_o), v_t'(0));
    chk("rmid_swv", v_t'(bus.sw_valid), v_t'(0));
    bus.sw_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmid_rdy", v_t'(bus.cmd_ready), v_t'(1));
    check_state("rmid");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
